// File: rtl/vga_pixel_fetcher.sv
// Framebuffer read stage: walks a linear 24-in-32-bit framebuffer over a Wishbone
// classic read master and buffers the pixels in a show-ahead FIFO for the display.
module vga_pixel_fetcher #(
  parameter int unsigned HDISP      = 800,
  parameter int unsigned VDISP      = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 256
) (
  input  logic                            pixel_clk,
  input  logic                            pixel_rst,
  input  logic                            frame_sync,
  input  logic                            pix_rd,
  output logic [23:0]                     pix_data,
  output logic                            pix_empty,
  output logic [$clog2(FIFO_DEPTH):0]     fill_level,
  output logic                            underflow,
  output logic                            wb_cyc,
  output logic                            wb_stb,
  output logic                            wb_we,
  output logic [31:0]                     wb_adr,
  output logic [3:0]                      wb_sel,
  input  logic [31:0]                     wb_dat_i,
  input  logic                            wb_ack
);

  localparam int unsigned TOTAL = HDISP * VDISP;
  localparam int          CW    = $clog2(TOTAL + 1);
  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam int          LW    = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    adr_q, adr_d;
  logic           cyc_q, cyc_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           underflow_q, underflow_d;
  logic           push, pop, empty;

  logic [23:0]    mem [FIFO_DEPTH];

  // Upper byte of the memory word carries no pixel information.
  logic unused_dat;
  assign unused_dat = ^wb_dat_i[31:24];

  assign empty = (level_q == '0);

  // Pure datapath decode; frame_sync overrides everything so an ack that
  // lands on the flush edge is discarded along with the rest of the FIFO.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    push        = wb_ack && cyc_q && (state_q == FETCH) && !frame_sync;
    pop         = pix_rd && !empty && !frame_sync;
    state_d     = state_q;
    count_d     = count_q;
    adr_d       = adr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    underflow_d = underflow_q;

    if (frame_sync) begin
      state_d     = FETCH;
      count_d     = '0;
      adr_d       = BASE_ADDR;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      underflow_d = 1'b0;
    end else begin
      if (push) begin
        count_d  = count_q + CW'(1);
        adr_d    = adr_q + 32'd4;
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (count_q == CW'(TOTAL - 1)) state_d = DONE;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (pix_rd && empty) underflow_d = 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end

    // Request only while the next cycle is still fetching and the FIFO has room,
    // so at most one ack can arrive with the FIFO at DEPTH-1.
    cyc_d = (state_d == FETCH) && (level_d < LW'(FIFO_DEPTH));
  end

  always_ff @(posedge pixel_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (pixel_rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      adr_q       <= BASE_ADDR;
      cyc_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      adr_q       <= adr_d;
      cyc_q       <= cyc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the level and pointers alone define valid contents.
  always_ff @(posedge pixel_clk) begin
    if (push) mem[wr_ptr_q] <= wb_dat_i[23:0];
  end

  assign pix_data   = empty ? 24'h0 : mem[rd_ptr_q];
  assign pix_empty  = empty;
  assign fill_level = level_q;
  assign underflow  = underflow_q;
  assign wb_cyc     = cyc_q;
  assign wb_stb     = cyc_q;
  assign wb_we      = 1'b0;
  assign wb_adr     = adr_q;
  assign wb_sel     = 4'hF;

endmodule

// File: tb/tb_vga_pixel_fetcher.sv
// Directed bench: a 4x2 frame with a deep FIFO driven from a vector table, plus a
// hand-written backpressure sequence on a 4-entry FIFO instance.
module tb_vga_pixel_fetcher;

  logic pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 4x2 frame, 256-entry FIFO, base 0.
  logic        a_rst = 1'b1, a_sync = 1'b0, a_rd = 1'b0;
  logic [23:0] a_data;
  logic        a_empty, a_uf, a_cyc, a_stb, a_we, a_ack;
  logic [8:0]  a_level;
  logic [31:0] a_adr, a_dat;
  logic [3:0]  a_sel;
  int          a_acks = 0;

  // Zero-wait slave returning the address with junk in the top byte.
  assign a_ack = a_cyc;
  assign a_dat = {8'hA5, a_adr[23:0]};

  vga_pixel_fetcher #(.HDISP(4), .VDISP(2), .BASE_ADDR(32'h0), .FIFO_DEPTH(256)) dut_a (
    .pixel_clk(pixel_clk), .pixel_rst(a_rst), .frame_sync(a_sync), .pix_rd(a_rd),
    .pix_data(a_data), .pix_empty(a_empty), .fill_level(a_level), .underflow(a_uf),
    .wb_cyc(a_cyc), .wb_stb(a_stb), .wb_we(a_we), .wb_adr(a_adr), .wb_sel(a_sel),
    .wb_dat_i(a_dat), .wb_ack(a_ack)
  );

  // Instance B: 8x2 frame, 4-entry FIFO, base 0x1000.
  logic        b_rst = 1'b1, b_sync = 1'b0, b_rd = 1'b0;
  logic [23:0] b_data;
  logic        b_empty, b_uf, b_cyc, b_stb, b_we, b_ack;
  logic [2:0]  b_level;
  logic [31:0] b_adr, b_dat;
  logic [3:0]  b_sel;
  int          b_acks = 0;

  assign b_ack = b_cyc;
  assign b_dat = {8'h5A, b_adr[23:0]};

  vga_pixel_fetcher #(.HDISP(8), .VDISP(2), .BASE_ADDR(32'h0000_1000), .FIFO_DEPTH(4)) dut_b (
    .pixel_clk(pixel_clk), .pixel_rst(b_rst), .frame_sync(b_sync), .pix_rd(b_rd),
    .pix_data(b_data), .pix_empty(b_empty), .fill_level(b_level), .underflow(b_uf),
    .wb_cyc(b_cyc), .wb_stb(b_stb), .wb_we(b_we), .wb_adr(b_adr), .wb_sel(b_sel),
    .wb_dat_i(b_dat), .wb_ack(b_ack)
  );

  always_ff @(posedge pixel_clk) begin
    if (a_cyc === 1'b1) a_acks <= a_acks + 1;
    if (b_cyc === 1'b1) b_acks <= b_acks + 1;
  end

  typedef struct {
    logic        rst, sync, rd;
    logic        cyc;
    logic [31:0] adr;
    int          level;
    logic        empty, uf;
    logic [23:0] data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic sync, input logic rd, input logic cyc,
                     input logic [31:0] adr, input int level, input logic empty,
                     input logic uf, input logic [23:0] data);
    vec_t v;
    v.rst = rst; v.sync = sync; v.rd = rd; v.cyc = cyc; v.adr = adr;
    v.level = level; v.empty = empty; v.uf = uf; v.data = data;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  initial begin
    // Inputs are applied for one cycle; expectations are the outputs after that edge.
    add(1, 0, 0,  0, 32'd0, 0, 1, 0, 24'h0);           // reset
    add(0, 0, 0,  0, 32'd0, 0, 1, 0, 24'h0);           // idle: no requests
    add(0, 1, 0,  1, 32'd0, 0, 1, 0, 24'h0);           // frame_sync -> strobe at base
    for (int k = 1; k <= 8; k++)
      add(0, 0, 0, (k < 8), 32'(4 * k), k, 0, 0, 24'h0); // one ack per cycle
    add(0, 0, 0,  0, 32'd32, 8, 0, 0, 24'h0);          // DONE holds
    for (int j = 1; j <= 8; j++)
      add(0, 0, 1, 0, 32'd32, 8 - j, (j == 8), 0, (j < 8) ? 24'(4 * j) : 24'h0);
    add(0, 0, 1,  0, 32'd32, 0, 1, 1, 24'h0);          // pop while empty
    add(0, 0, 0,  0, 32'd32, 0, 1, 1, 24'h0);          // underflow sticky
    add(0, 1, 0,  1, 32'd0, 0, 1, 0, 24'h0);           // sync clears underflow
    add(0, 0, 0,  1, 32'd4, 1, 0, 0, 24'h0);
    add(0, 0, 0,  1, 32'd8, 2, 0, 0, 24'h0);
    add(0, 1, 0,  1, 32'd0, 0, 1, 0, 24'h0);           // sync with ack: ack dropped
    add(0, 0, 0,  1, 32'd4, 1, 0, 0, 24'h0);
    add(0, 0, 1,  1, 32'd8, 1, 0, 0, 24'h4);           // push+pop non-empty
    add(0, 1, 0,  1, 32'd0, 0, 1, 0, 24'h0);
    add(0, 0, 1,  1, 32'd4, 1, 0, 1, 24'h0);           // push+pop while empty
    add(1, 0, 0,  0, 32'd0, 0, 1, 0, 24'h0);           // reset mid-burst
    add(0, 0, 0,  0, 32'd0, 0, 1, 0, 24'h0);
    add(0, 0, 0,  0, 32'd0, 0, 1, 0, 24'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      a_rst  = vecs[i].rst;
      a_sync = vecs[i].sync;
      a_rd   = vecs[i].rd;
      step();
      check($sformatf("a[%0d] cyc", i),   32'(a_cyc),   32'(vecs[i].cyc));
      check($sformatf("a[%0d] stb", i),   32'(a_stb),   32'(vecs[i].cyc));
      check($sformatf("a[%0d] adr", i),   a_adr,        vecs[i].adr);
      check($sformatf("a[%0d] level", i), 32'(a_level), 32'(vecs[i].level));
      check($sformatf("a[%0d] empty", i), 32'(a_empty), 32'(vecs[i].empty));
      check($sformatf("a[%0d] uf", i),    32'(a_uf),    32'(vecs[i].uf));
      check($sformatf("a[%0d] data", i),  32'(a_data),  32'(vecs[i].data));
      check($sformatf("a[%0d] we_sel", i), {27'd0, a_we, a_sel}, 32'h0000_000F);
      if (i == 11) check("a frame ack count", 32'(a_acks), 32'd8);
    end

    // Backpressure on a 4-entry FIFO.
    b_rst = 1'b1;
    step();
    check("b rst cyc", 32'(b_cyc), 32'd0);
    check("b rst adr", b_adr, 32'h0000_1000);
    check("b rst empty", 32'(b_empty), 32'd1);
    b_rst = 1'b0;
    b_sync = 1'b1;
    step();
    b_sync = 1'b0;
    check("b sync stb", 32'(b_stb), 32'd1);
    check("b sync adr", b_adr, 32'h0000_1000);
    repeat (4) step();
    check("b full level", 32'(b_level), 32'd4);
    check("b full stb", 32'(b_stb), 32'd0);
    check("b full adr", b_adr, 32'h0000_1010);
    check("b full head", 32'(b_data), 32'h0000_1000);
    check("b full acks", 32'(b_acks), 32'd4);
    repeat (3) step();
    check("b stall level", 32'(b_level), 32'd4);
    check("b stall stb", 32'(b_stb), 32'd0);
    check("b stall acks", 32'(b_acks), 32'd4);
    b_rd = 1'b1;
    step();
    b_rd = 1'b0;
    check("b pop level", 32'(b_level), 32'd3);
    check("b pop stb", 32'(b_stb), 32'd1);
    check("b pop head", 32'(b_data), 32'h0000_1004);
    step();
    check("b refill level", 32'(b_level), 32'd4);
    check("b refill stb", 32'(b_stb), 32'd0);
    check("b refill adr", b_adr, 32'h0000_1014);
    check("b refill acks", 32'(b_acks), 32'd5);
    repeat (2) step();
    check("b one more acks", 32'(b_acks), 32'd5);
    check("b one more level", 32'(b_level), 32'd4);
    for (int j = 1; j <= 3; j++) begin
      b_rd = 1'b1;
      step();
      b_rd = 1'b0;
      check($sformatf("b pop%0d head", j), 32'(b_data), 32'h0000_1004 + 32'(4 * j));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
